// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: follows fetched instructions through ID and EX and resolves
// conditional branches in EX. It emits a predictor training write, a mispredict pulse and saturating counters.
module branch_resolve_unit (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        en,
    input  logic        stall,
    input  logic        if_valid,
    input  logic [4:0]  if_idx,
    input  logic        if_pred,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    output logic        upd_en,
    output logic [4:0]  upd_addr,
    output logic        upd_taken,
    output logic        mispredict,
    output logic [15:0] branch_cnt,
    output logic [15:0] mispred_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
        logic       pred;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{valid: 1'b0, idx: 5'd0, pred: 1'b0};

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

    slot_t       s_id_q, s_id_d;
    slot_t       s_ex_q, s_ex_d;
    logic        upd_en_q, upd_en_d;
    logic [4:0]  upd_addr_q, upd_addr_d;
    logic        upd_taken_q, upd_taken_d;
    logic        mispredict_q, mispredict_d;
    logic [15:0] branch_cnt_q, branch_cnt_d;
    logic [15:0] mispred_cnt_q, mispred_cnt_d;

    logic advance_s;
    logic resolve_s;
    logic mismatch_s;

    // Resolution qualifiers: stall/en dominate, and an invalid EX slot masks ex_is_branch
    always_comb begin
        advance_s  = en & ~stall;
        resolve_s  = advance_s & s_ex_q.valid & ex_is_branch;
        mismatch_s = resolve_s & (ex_taken ^ s_ex_q.pred);
    end

    // Slot shifting; a mismatch squashes both younger instructions but still shifts their fields
    always_comb begin
        s_id_d = s_id_q;
        s_ex_d = s_ex_q;
        if (advance_s) begin
            s_ex_d       = s_id_q;
            s_ex_d.valid = s_id_q.valid & ~mismatch_s;
            s_id_d.valid = if_valid & ~mismatch_s;
            s_id_d.idx   = if_idx;
            s_id_d.pred  = if_pred;
        end else begin
            s_id_d = s_id_q;
            s_ex_d = s_ex_q;
        end
    end

    // Training write and mispredict pulse; address/outcome hold between updates
    always_comb begin
        upd_en_d     = resolve_s;
        mispredict_d = mismatch_s;
        upd_addr_d   = upd_addr_q;
        upd_taken_d  = upd_taken_q;
        if (resolve_s) begin
            upd_addr_d  = s_ex_q.idx;
            upd_taken_d = ex_taken;
        end else begin
            upd_addr_d  = upd_addr_q;
            upd_taken_d = upd_taken_q;
        end
    end

    // Saturating statistics counters; mispredicts are a subset of resolutions
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (resolve_s) begin
            branch_cnt_d = sat_inc(branch_cnt_q);
        end else begin
            branch_cnt_d = branch_cnt_q;
        end
        if (mismatch_s) begin
            mispred_cnt_d = sat_inc(mispred_cnt_q);
        end else begin
            mispred_cnt_d = mispred_cnt_q;
        end
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s_id_q        <= SLOT_EMPTY;
            s_ex_q        <= SLOT_EMPTY;
            upd_en_q      <= 1'b0;
            upd_addr_q    <= 5'd0;
            upd_taken_q   <= 1'b0;
            mispredict_q  <= 1'b0;
            branch_cnt_q  <= 16'd0;
            mispred_cnt_q <= 16'd0;
        end else begin
            s_id_q        <= s_id_d;
            s_ex_q        <= s_ex_d;
            upd_en_q      <= upd_en_d;
            upd_addr_q    <= upd_addr_d;
            upd_taken_q   <= upd_taken_d;
            mispredict_q  <= mispredict_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign upd_en      = upd_en_q;
    assign upd_addr    = upd_addr_q;
    assign upd_taken   = upd_taken_q;
    assign mispredict  = mispredict_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: the driver consults a queue-based model of in-flight
// instructions and pushes the expected updates; a negedge monitor pops them and compares.
module tb_branch_resolve_unit;

    logic        clk;
    logic        arst_n;
    logic        en, stall, if_valid, if_pred, ex_is_branch, ex_taken;
    logic [4:0]  if_idx;
    logic        upd_en, upd_taken, mispredict;
    logic [4:0]  upd_addr;
    logic [15:0] branch_cnt, mispred_cnt;

    branch_resolve_unit dut (
        .clk(clk), .arst_n(arst_n), .en(en), .stall(stall),
        .if_valid(if_valid), .if_idx(if_idx), .if_pred(if_pred),
        .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
        .upd_en(upd_en), .upd_addr(upd_addr), .upd_taken(upd_taken),
        .mispredict(mispredict), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    typedef struct {
        bit       valid;
        bit [4:0] idx;
        bit       pred;
    } insn_t;

    typedef struct {
        int        stamp;
        bit [4:0]  addr;
        bit        taken;
        bit        mis;
        bit [15:0] bc;
        bit [15:0] mc;
    } exp_t;

    insn_t pipe[$];     // pipe[0] is the instruction in EX, pipe[1] the one in ID
    exp_t  exp_q[$];
    int    m_bc, m_mc;
    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void model_reset();
        insn_t blank;
        blank.valid = 1'b0; blank.idx = 5'd0; blank.pred = 1'b0;
        pipe.delete();
        pipe.push_back(blank);
        pipe.push_back(blank);
        exp_q.delete();
        m_bc = 0;
        m_mc = 0;
    endfunction

    // Reference behaviour of one clock edge, expressed as instructions moving down a 2-deep queue
    function automatic void model_edge(bit e, bit st, bit fv, bit [4:0] fi, bit fp, bit xb, bit xt);
        insn_t nw;
        exp_t  ex;
        bit    flush;
        flush = 1'b0;
        if (e && !st) begin
            if (pipe[0].valid && xb) begin
                flush = (xt != pipe[0].pred);
                if (m_bc < 65535) m_bc = m_bc + 1;
                if (flush && m_mc < 65535) m_mc = m_mc + 1;
                ex.stamp = cyc + 1;
                ex.addr  = pipe[0].idx;
                ex.taken = xt;
                ex.mis   = flush;
                ex.bc    = m_bc[15:0];
                ex.mc    = m_mc[15:0];
                exp_q.push_back(ex);
            end
            nw.valid = fv;
            nw.idx   = fi;
            nw.pred  = fp;
            void'(pipe.pop_front());
            pipe.push_back(nw);
            if (flush) begin
                foreach (pipe[i]) pipe[i].valid = 1'b0;
            end
        end
    endfunction

    task automatic step(input bit e, input bit st, input bit fv, input bit [4:0] fi,
                        input bit fp, input bit xb, input bit xt);
        @(negedge clk);
        #1;
        en = e; stall = st; if_valid = fv; if_idx = fi; if_pred = fp;
        ex_is_branch = xb; ex_taken = xt;
        model_edge(e, st, fv, fi, fp, xb, xt);
    endtask

    task automatic check(input string name, input int got, input int want);
        vectors = vectors + 1;
        if (got != want) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        check("reset_outputs_zero", {upd_en, upd_addr, upd_taken, mispredict, branch_cnt, mispred_cnt}, 0);
        model_reset();
        en = 1'b0; stall = 1'b0; if_valid = 1'b0; if_idx = 5'd0; if_pred = 1'b0;
        ex_is_branch = 1'b0; ex_taken = 1'b0;
        @(negedge clk);
        #1;
        arst_n = 1'b1;
    endtask

    // Monitor: pops the expected update due this cycle, or requires upd_en and mispredict low
    always @(negedge clk) begin
        if (arst_n) begin
            if (exp_q.size() > 0 && exp_q[0].stamp == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                vectors = vectors + 1;
                if (!upd_en || upd_addr != e.addr || upd_taken != e.taken || mispredict != e.mis ||
                    branch_cnt != e.bc || mispred_cnt != e.mc) begin
                    miscompares = miscompares + 1;
                    $display("FAIL update@%0d: got en=%0b addr=%0d tk=%0b mis=%0b bc=%0d mc=%0d, want en=1 addr=%0d tk=%0b mis=%0b bc=%0d mc=%0d",
                             cyc, upd_en, upd_addr, upd_taken, mispredict, branch_cnt, mispred_cnt,
                             e.addr, e.taken, e.mis, e.bc, e.mc);
                end
            end else begin
                vectors = vectors + 1;
                if (upd_en || mispredict) begin
                    miscompares = miscompares + 1;
                    $display("FAIL idle@%0d: got upd_en=%0b mispredict=%0b, want 0 0", cyc, upd_en, mispredict);
                end
            end
        end
    end

    initial begin
        arst_n = 1'b0;
        en = 1'b0; stall = 1'b0; if_valid = 1'b0; if_idx = 5'd0; if_pred = 1'b0;
        ex_is_branch = 1'b0; ex_taken = 1'b0;
        model_reset();
        #1;
        check("por_outputs_zero", {upd_en, upd_addr, upd_taken, mispredict, branch_cnt, mispred_cnt}, 0);
        @(negedge clk);
        arst_n = 1'b1;

        // Correct prediction on idx 5
        step(1, 0, 1, 5'd5, 1, 0, 0);
        step(1, 0, 0, 5'd0, 0, 0, 0);
        step(1, 0, 0, 5'd0, 0, 1, 1);
        step(1, 0, 0, 5'd0, 0, 0, 0);
        check("branch_cnt_after_hit", branch_cnt, 1);

        // Mispredict on idx 3 squashes idx 4 and the concurrent fetch
        step(1, 0, 1, 5'd3, 0, 0, 0);
        step(1, 0, 1, 5'd4, 1, 0, 0);
        step(1, 0, 1, 5'd7, 1, 1, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 5'd0, 0, 1, 0);
        check("mispred_cnt_after_flush", mispred_cnt, 1);

        // Stall deferral: resolution waits out three stalled cycles
        step(1, 0, 1, 5'd9, 0, 0, 0);
        step(1, 0, 0, 5'd0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 5'd0, 0, 1, 0);
        step(1, 0, 0, 5'd0, 0, 1, 0);
        step(0, 0, 0, 5'd0, 0, 1, 0);
        step(1, 0, 0, 5'd0, 0, 1, 0);
        check("branch_cnt_after_stall", branch_cnt, 3);

        // Reset with both slots valid; nothing may resolve until new fetches arrive
        step(1, 0, 1, 5'd11, 1, 0, 0);
        step(1, 0, 1, 5'd12, 1, 0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 5'd0, 0, 1, 1);
        check("branch_cnt_after_reset", branch_cnt, 0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            bit xt;
            xt = ($urandom_range(0, 2) != 0) ? pipe[0].pred : ~pipe[0].pred;
            step($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0,
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, xt);
        end
        for (int i = 0; i < 3; i++) step(1, 0, 0, 5'd0, 0, 0, 0);
        check("rand_branch_cnt", branch_cnt, m_bc);
        check("rand_mispred_cnt", mispred_cnt, m_mc);

        // Saturation: 65535 correct resolutions, then one mismatch
        do_reset();
        for (int i = 0; i < 65537; i++) step(1, 0, 1, 5'(i), 1, 1, 1);
        step(1, 0, 1, 5'd1, 1, 1, 0);
        step(1, 0, 0, 5'd0, 0, 0, 0);
        check("sat_branch_cnt", branch_cnt, 16'hFFFF);
        check("sat_mispred_cnt", mispred_cnt, 1);

        step(1, 0, 0, 5'd0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
